cache_mem_arbiter: RTL
======================

// Module: cache_mem_arbiter
// PURPOSE
//   Sits directly downstream of the i/d cache pair and upstream of the single-port RAM.
//   Arbitrates icache fills (read-only) and dcache fills/writebacks (read/write) onto one RAM port.
//   Returns wait/load to the winning cache.
//   Dcache has priority; a bounded streak counter prevents icache starvation.
// PARAMETERS
//   ISTARVE_MAX  4  max consecutive dcache grants while icache waits; 0 = pure dcache priority
//   AW           32 address width
//   DW           32 data width
// PORTS
//   CLK       in  1   clock, rising edge
//   nRST      in  1   asynchronous active-low reset
//   iREN      in  1   icache read request
//   iaddr     in  AW  icache address
//   iwait     out 1   icache stall; low exactly in icache's ACCESS cycle
//   iload     out DW  icache read data, valid when iwait=0
//   dREN      in  1   dcache read request
//   dWEN      in  1   dcache write request; wins if dREN=dWEN=1
//   daddr     in  AW  dcache address
//   dstore    in  DW  dcache write data
//   dwait     out 1   dcache stall; low exactly in dcache's ACCESS cycle
//   dload     out DW  dcache read data, valid when dwait=0
//   ramREN    out 1   RAM read strobe
//   ramWEN    out 1   RAM write strobe
//   ramaddr   out AW  RAM address
//   ramstore  out DW  RAM write data
//   ramload   in  DW  RAM read data
//   ramstate  in  2   0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
// BEHAVIOUR
//   FSM states: IDLE, IGNT, DGNT. Registered state; all outputs decoded combinationally from state+ramstate.
//   IDLE
//     RAM strobes 0; ramaddr/ramstore 0; iwait=iREN; dwait=dREN|dWEN.
//     Next state:
//       d pending only                         -> DGNT
//       i pending only                         -> IGNT
//       both pending, dstreak<ISTARVE_MAX      -> DGNT
//       both pending, dstreak==ISTARVE_MAX     -> IGNT
//       none pending                           -> stay IDLE
//   IGNT
//     ramREN=iREN; ramaddr=iaddr; dwait follows dcache request.
//     ramstate==ACCESS: iwait=0, iload=ramload, next IDLE.
//     Otherwise iwait=1, stay.
//   DGNT
//     ramWEN=dWEN; ramREN=dREN&~dWEN; ramaddr=daddr; ramstore=dstore; iwait=iREN.
//     ramstate==ACCESS: dwait=0, dload=ramload, next IDLE.
//     Otherwise dwait=1, stay.
//   Non-granted requester: wait=1 whenever requesting; load=0.
//   Latency: minimum 2 cycles per request (IDLE arbitration + 1 grant cycle). Back-to-back grants are separated by one IDLE cycle.
//   ERROR or BUSY: hold grant and strobes; wait stays high; RAM retries. No abort, no error reporting.
//   Requester drops its request while granted, before ACCESS:
//     strobes drop that cycle; wait=1; next IDLE; no streak update.
//   dstreak counter, width clog2(ISTARVE_MAX+1); updated on the IDLE->grant transition:
//     DGNT chosen while iREN=1          -> increment, saturate at ISTARVE_MAX
//     IGNT chosen                       -> clear to 0
//     DGNT chosen while iREN=0          -> clear to 0
//   Reset, any cycle, including mid-grant:
//     state IDLE, dstreak 0.
//     All RAM outputs 0; iload/dload 0.
//     iwait/dwait follow the IDLE rule.
//   Never drive ramREN and ramWEN high in the same cycle.
//   Never drop a wait for a requester that is not granted.
// TESTING
//   1. icache only: iREN=1, iaddr=0x40; RAM ACCESS on the 2nd grant cycle, ramload=0xDEADBEEF.
//      -> ramREN high for 2 cycles; iwait low in exactly 1 cycle with iload=0xDEADBEEF; then IDLE.
//   2. Simultaneous iREN and dWEN, daddr=0x80, dstore=0x1234, dstreak=0.
//      -> DGNT first: ramWEN=1, ramstore=0x1234.
//      -> After dcache ACCESS, one IDLE cycle, then IGNT.
//   3. Starvation, ISTARVE_MAX=4: iREN held high, dREN re-asserted after every ACCESS.
//      -> Exactly 4 dcache grants, then an icache grant; dstreak back to 0.
//   4. ramstate=ERROR for 3 cycles, then ACCESS, during DGNT.
//      -> Strobes and ramaddr stable throughout; dwait high until the ACCESS cycle.
//   5. nRST asserted mid-IGNT while ramstate=BUSY.
//      -> Same cycle: ramREN=0, iload=0, state IDLE.
//      -> After release with iREN still high: re-grant, full 2-cycle minimum latency.
//   6. dREN=dWEN=1 in the same cycle.
//      -> ramWEN=1, ramREN=0; exactly one ACCESS completes the request.

Source files
------------

// File: rtl/cache_mem_arbiter_if.sv
// Bus bundle between the i/d cache pair, the arbiter and the single-port RAM.
// The slave modport is the arbiter's view; the master modport is the caches/RAM side.
interface cache_mem_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          iREN;
    logic [AW-1:0] iaddr;
    logic          iwait;
    logic [DW-1:0] iload;
    logic          dREN;
    logic          dWEN;
    logic [AW-1:0] daddr;
    logic [DW-1:0] dstore;
    logic          dwait;
    logic [DW-1:0] dload;
    logic          ramREN;
    logic          ramWEN;
    logic [AW-1:0] ramaddr;
    logic [DW-1:0] ramstore;
    logic [DW-1:0] ramload;
    logic [1:0]    ramstate;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Arbitrates icache fills and dcache fills/writebacks onto one RAM port.
// Dcache wins ties until a streak of ISTARVE_MAX grants forces an icache turn.
module cache_mem_arbiter #(
    parameter int unsigned ISTARVE_MAX = 4,
    parameter int unsigned AW          = 32,
    parameter int unsigned DW          = 32
) (
    input  logic                 CLK,
    input  logic                 nRST,
    cache_mem_arbiter_if.slave   bus
);
    localparam int unsigned SW = (ISTARVE_MAX > 0) ? $clog2(ISTARVE_MAX + 1) : 1;
    localparam logic [SW-1:0] SMAX = SW'(ISTARVE_MAX);
    localparam logic [1:0] RAM_ACCESS = 2'd2;

    typedef enum logic [1:0] {IDLE, IGNT, DGNT} state_e;

    state_e        state_q, state_d;
    logic [SW-1:0] streak_q, streak_d;

    logic d_req;
    logic starve;
    logic access;

    assign d_req  = bus.dREN | bus.dWEN;
    // A zero limit disables the starvation guard entirely.
    assign starve = (ISTARVE_MAX != 0) && (streak_q == SMAX);
    assign access = (bus.ramstate == RAM_ACCESS);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        streak_d     = streak_q;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.iwait    = bus.iREN;
        bus.dwait    = d_req;
        bus.iload    = '0;
        bus.dload    = '0;

        unique case (state_q)
            IDLE: begin
                if (d_req && !(bus.iREN && starve)) begin
                    state_d = DGNT;
                    if (!bus.iREN)
                        streak_d = '0;
                    else if (streak_q != SMAX)
                        streak_d = streak_q + 1'b1;
                end else if (bus.iREN) begin
                    state_d  = IGNT;
                    streak_d = '0;
                end
            end
            IGNT: begin
                bus.ramaddr = bus.iaddr;
                if (!bus.iREN) begin
                    bus.iwait = 1'b1;
                    state_d   = IDLE;
                end else begin
                    bus.ramREN = 1'b1;
                    if (access) begin
                        bus.iwait = 1'b0;
                        bus.iload = bus.ramload;
                        state_d   = IDLE;
                    end else begin
                        bus.iwait = 1'b1;
                    end
                end
            end
            DGNT: begin
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                if (!d_req) begin
                    bus.dwait = 1'b1;
                    state_d   = IDLE;
                end else begin
                    // Write wins over read so the strobes are never both high.
                    bus.ramWEN = bus.dWEN;
                    bus.ramREN = bus.dREN & ~bus.dWEN;
                    if (access) begin
                        bus.dwait = 1'b0;
                        bus.dload = bus.ramload;
                        state_d   = IDLE;
                    end else begin
                        bus.dwait = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
